// File: rtl/gray_to_binary_decoder.sv
// Serial Gray-to-binary decoder: accepts one Gray word per handshake, decodes MSB-first one bit per clock.
// Optional adjacency checking against the previous word is enabled by defining GRAY2BIN_ADJ_CHECK_EN.
module gray_to_binary_decoder #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             adj_err
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        HOLD
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shift_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic               run_bit;
    logic               new_bit;
    logic               accept;

    assign accept  = (state == IDLE) && in_valid && in_ready;

    // Each decoded bit is the previous binary bit XOR the current Gray bit at the top of the shifter.
    assign new_bit = run_bit ^ shift_reg[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            bin_out   <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            run_bit   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= gray_in;
                        bit_cnt   <= CNT_W'(WIDTH - 1);
                        run_bit   <= 1'b0;
                        in_ready  <= 1'b0;
                        state     <= DECODE;
                    end else begin
                        in_ready  <= 1'b1;
                    end
                end
                DECODE: begin
                    bin_out   <= {bin_out[WIDTH-2:0], new_bit};
                    run_bit   <= new_bit;
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    bit_cnt   <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == '0) begin
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef GRAY2BIN_ADJ_CHECK_EN
    logic [WIDTH-1:0] prev_gray;
    logic             first_word;
    logic             adj_pend;
    logic             adj_now;

    assign adj_now = !first_word && ($countones(prev_gray ^ gray_in) != 1);

    // The verdict is computed at accept and only exposed once the word reaches HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray  <= '0;
            first_word <= 1'b1;
            adj_pend   <= 1'b0;
            adj_err    <= 1'b0;
        end else begin
            if (accept) begin
                adj_pend   <= adj_now;
                prev_gray  <= gray_in;
                first_word <= 1'b0;
            end
            if (state == DECODE && bit_cnt == '0) begin
                adj_err <= adj_pend;
            end else if (state == HOLD && out_ready) begin
                adj_err <= 1'b0;
            end
        end
    end
`else
    assign adj_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_binary_decoder.sv
// Directed self-checking bench for gray_to_binary_decoder (WIDTH=3), with adjacency expectations
// following whether GRAY2BIN_ADJ_CHECK_EN is defined.
module tb_gray_to_binary_decoder;

    localparam int WIDTH = 3;
`ifdef GRAY2BIN_ADJ_CHECK_EN
    localparam bit ADJ_ON = 1'b1;
`else
    localparam bit ADJ_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] gray_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] bin_out;
    logic             adj_err;

    int assert_count = 0;
    int fail_count   = 0;

    gray_to_binary_decoder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gray_in   (gray_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .adj_err   (adj_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assert_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 16'(in_ready), 16'd0);
        checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
        checkOutput("rst_bin_out", 16'(bin_out), 16'd0);
        checkOutput("rst_adj_err", 16'(adj_err), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 16'(in_ready), 16'd1);
    endtask

    // Called at a negedge with in_ready expected high; returns at the negedge after the result is consumed.
    task automatic applyStimulus(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] exp_bin,
                                 input logic exp_adj, input bit hold_valid);
        checkOutput("idle_in_ready", 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        gray_in  = g;
        @(negedge clk);
        if (!hold_valid) in_valid = 1'b0;
        gray_in = ~g;
        for (int k = 0; k < WIDTH; k++) begin
            checkOutput("decode_out_valid", 16'(out_valid), 16'd0);
            checkOutput("decode_in_ready", 16'(in_ready), 16'd0);
            @(negedge clk);
        end
        checkOutput("hold_out_valid", 16'(out_valid), 16'd1);
        checkOutput("hold_in_ready", 16'(in_ready), 16'd0);
        checkOutput("hold_bin_out", 16'(bin_out), 16'(exp_bin));
        checkOutput("hold_adj_err", 16'(adj_err), 16'(exp_adj & ADJ_ON));
        @(negedge clk);
        checkOutput("done_out_valid", 16'(out_valid), 16'd0);
        checkOutput("done_in_ready", 16'(in_ready), 16'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] sweep_bin [8];
        logic             sweep_adj [8];
        sweep_bin = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b111, 3'b110, 3'b100, 3'b101};
        sweep_adj = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        applyReset();

        // Single words with gaps
        applyStimulus(3'b110, 3'b100, 1'b0, 1'b0);
        applyStimulus(3'b010, 3'b011, 1'b0, 1'b0);
        applyStimulus(3'b111, 3'b101, 1'b1, 1'b0);

        // Back-to-back sweep with in_valid held high: one word every 5 cycles
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), sweep_bin[i], sweep_adj[i], 1'b1);
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Backpressure: 10 stalled cycles in HOLD with a noisy source
        out_ready = 1'b0;
        in_valid  = 1'b1;
        gray_in   = 3'b101;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (WIDTH) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            gray_in  = ~gray_in;
            checkOutput("bp_out_valid", 16'(out_valid), 16'd1);
            checkOutput("bp_bin_out", 16'(bin_out), 16'(3'b110));
            checkOutput("bp_in_ready", 16'(in_ready), 16'd0);
            checkOutput("bp_adj_err", 16'(adj_err), 16'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_out_valid", 16'(out_valid), 16'd0);
        checkOutput("bp_release_in_ready", 16'(in_ready), 16'd1);

        // Reset asserted on the second DECODE cycle
        in_valid = 1'b1;
        gray_in  = 3'b110;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out_valid", 16'(out_valid), 16'd0);
        checkOutput("midrst_bin_out", 16'(bin_out), 16'd0);
        checkOutput("midrst_in_ready", 16'(in_ready), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_release_in_ready", 16'(in_ready), 16'd1);
        applyStimulus(3'b011, 3'b010, 1'b0, 1'b0);

        // Adjacency sequence from a fresh reset
        applyReset();
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
        applyStimulus(3'b001, 3'b001, 1'b0, 1'b0);
        applyStimulus(3'b011, 3'b010, 1'b0, 1'b0);
        applyStimulus(3'b000, 3'b000, 1'b1, 1'b0);
        applyStimulus(3'b001, 3'b001, 1'b0, 1'b0);
        applyStimulus(3'b001, 3'b001, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/gray_to_binary_decoder.md
# gray_to_binary_decoder

Serial Gray-to-binary decoder: the receive-side counterpart of the team's binary-to-Gray encoder. It accepts one Gray-coded word per valid/ready handshake, decodes it MSB-first at one bit per clock, and presents the binary result on a valid/ready output port. It sits downstream of any Gray-coded source, such as a position encoder or counter, and feeds binary consumers.

## Interface
Parameters:
- WIDTH, 3, word width in bits; legal range 2..16.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  gray_in is valid.
- in_ready  output  1  decoder can accept a word.
- gray_in  input  WIDTH  Gray-coded input word.
- out_valid  output  1  bin_out holds a completed result.
- out_ready  input  1  consumer accepts the result.
- bin_out  output  WIDTH  decoded binary word.
- adj_err  output  1  adjacency-error flag; see Configuration.

## Operation
- FSM states are IDLE, DECODE and HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - capture gray_in into the shift register;
  - load the bit counter with WIDTH-1;
  - move to DECODE.
- DECODE: in_ready=0 and out_valid=0. Each cycle computes one bit, MSB first:
  - bin[WIDTH-1] = g[WIDTH-1];
  - bin[i] = bin[i+1] ^ g[i];
  - the counter decrements each cycle;
  - after the cycle that computes bin[0], move to HOLD.
- HOLD: out_valid=1, and bin_out and adj_err are held stable. On out_ready=1 the FSM moves to IDLE. in_ready rises on the next cycle; no same-cycle turnaround.
- gray_in is sampled only at the accept edge. Later changes to gray_in have no effect on the word in progress.
- bin_out is defined only while out_valid=1. During DECODE it may show partial bits.
- in_valid while in DECODE or HOLD is ignored. The source must hold the word until in_ready is high.
- Reset (rst=1 at any edge, including mid-DECODE or mid-HOLD):
  - state goes to IDLE and the word in progress is discarded;
  - in_ready=0 while rst is asserted, and 1 on the first cycle after release;
  - out_valid=0, bin_out=0, adj_err=0;
  - counter=0, shift register=0, first-word flag set.

## Timing
- Accept edge is E. out_valid is first seen high WIDTH cycles after E: for WIDTH=3, accept at E0 gives out_valid high after E3.
- Minimum period per word is WIDTH+2 cycles: 1 cycle in IDLE, WIDTH cycles in DECODE, 1 cycle in HOLD with out_ready=1.
- There are no combinational paths from input to output. All outputs are registered or decoded from registered state.
- There is no limit on HOLD duration under backpressure, and no data is lost.

## Configuration
- Macro: GRAY2BIN_ADJ_CHECK_EN.
- Defined: the block keeps the previously accepted Gray word and checks each new word against it.
  - In HOLD, adj_err=1 if popcount(prev ^ curr) != 1; identical words therefore flag.
  - The first word after reset never flags.
  - prev updates at each accept edge.
- Undefined: adj_err is tied to 0 and the compare logic and prev register are not built. All other behaviour is identical.

## Test plan
- Reset then single words, WIDTH=3, out_ready=1:
  - gray 3'b110 -> bin 3'b100;
  - 3'b010 -> 3'b011;
  - 3'b111 -> 3'b101;
  - each with out_valid exactly WIDTH cycles after accept and in_ready low throughout.
- Exhaustive sweep of all 8 Gray codes back-to-back -> bin_out equals the reference decode for every word; spacing is exactly 5 cycles with in_valid held high.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD while gray_in toggles -> bin_out is stable, in_ready=0, and the result is consumed on the first out_ready=1.
- Reset mid-DECODE (rst on the second DECODE cycle) -> next cycle out_valid=0, bin_out=0; next word 3'b011 decodes to 3'b010 with normal latency.
- Macro defined:
  - sequence 000, 001, 011, 000 -> adj_err 0, 0, 0, 1 (the 011->000 step flips two bits);
  - repeated 001, 001 -> second word flags 1.
- Macro undefined: rerun the previous sequence -> adj_err stays 0 and all decodes are correct.
